// File: rtl/nco_clock_divider.sv
// Fractional (NCO) / integer clock divider with glitch-free start, stop and mode change.
// clk_out is a registered enable-style clock. A stop always waits for the end of a high phase.
module nco_clock_divider #(
  parameter int ACC_W       = 24,
  parameter int N_CH        = 4,
  parameter int DIV_N       = 4,
  parameter int DEFAULT_INC = 4529848
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  valid,
  input  logic [1:0]       mux_ctrl,
  input  logic [ACC_W-1:0] inc,
  input  logic             inc_load,
  output logic             clk_out,
  output logic             tick,
  output logic [15:0]      tick_cnt,
  output logic             busy,
  output logic [1:0]       state_o
);

  localparam int CNT_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_N - 1);
  localparam logic [ACC_W-1:0] HALF_INC = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] DEF_INC = ACC_W'(DEFAULT_INC);
  localparam logic [1:0] MODE_NCO = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic             busy_q, busy_d;

  logic             en;
  logic             mode_ok;
  logic             leave_run;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] gen_acc;
  logic [CNT_W-1:0] gen_cnt;
  logic             gen_clk;

  assign en        = |valid;
  assign mode_ok   = ~mux_ctrl[1];
  assign leave_run = ~en | (mux_ctrl != mode_q);
  assign acc_sum   = acc_q + inc_q;

  // One generation step in the latched mode; used by RUN and DRAIN alike.
  always_comb begin
    gen_acc = acc_q;
    gen_cnt = cnt_q;
    gen_clk = clk_q;
    if (mode_q == MODE_NCO) begin
      gen_acc = acc_sum;
      gen_clk = acc_sum[ACC_W-1];
    end else if (cnt_q == CNT_MAX) begin
      gen_cnt = '0;
      gen_clk = ~clk_q;
    end else begin
      gen_cnt = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    clk_d   = clk_q;
    inc_d   = inc_q;

    if (inc_load && (inc != '0)) begin
      inc_d = (inc > HALF_INC) ? HALF_INC : inc;
    end

    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        clk_d = 1'b0;
        if (en && mode_ok) begin
          mode_d  = mux_ctrl;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (leave_run && !clk_q) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          acc_d = gen_acc;
          cnt_d = gen_cnt;
          clk_d = gen_clk;
          if (leave_run) begin
            // A high phase that ends on the exit edge needs no DRAIN cycle.
            state_d = gen_clk ? ST_DRAIN : ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        acc_d = gen_acc;
        cnt_d = gen_cnt;
        clk_d = gen_clk;
        if (!gen_clk) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clk_d   = 1'b0;
      end
    endcase

    if (state_d == ST_IDLE) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  assign tick_d     = ~clk_q & clk_d;
  assign tick_cnt_d = tick_cnt_q + 16'(tick_d);
  assign busy_d     = (state_d != ST_IDLE);

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= MODE_NCO;
      clk_q      <= 1'b0;
      inc_q      <= DEF_INC;
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      clk_q      <= clk_d;
      inc_q      <= inc_d;
      tick_q     <= tick_d;
      tick_cnt_q <= tick_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign clk_out  = clk_q;
  assign tick     = tick_q;
  assign tick_cnt = tick_cnt_q;
  assign busy     = busy_q;
  assign state_o  = state_q;

endmodule
